// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame geometry.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous UART inputs; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= 2'b11;
        else     ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver, 8-N-1 by default; define UART_RX_PARITY_EN for 8-E-1
// with a registered parity_err flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bitidx;
    logic [DATA_BITS-1:0] shreg;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
    logic par_mis;
    logic par_err_q;

    // Mismatch is captured at the parity sample and published with the stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_mis   <= 1'b0;
            par_err_q <= 1'b0;
        end else if (enb && cnt == CNT_END) begin
            if (state == PARITY) par_mis   <= (^shreg) ^ rxs;
            if (state == STOP)   par_err_q <= par_mis;
        end
    end

    assign parity_err = par_err_q;
`else
    localparam rx_state_t AFTER_DATA = STOP;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bitidx      <= '0;
            shreg       <= '0;
            data_out    <= '0;
            rdy         <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // Completion below is assigned later, so a coincident set wins over the clear.
            if (rdy_clr) begin
                rdy         <= 1'b0;
                overrun_err <= 1'b0;
            end
            if (enb) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == CNT_MID) begin
                            cnt    <= '0;
                            bitidx <= '0;
                            state  <= rxs ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_END) begin
                            shreg  <= {rxs, shreg[DATA_BITS-1:1]};
                            cnt    <= '0;
                            bitidx <= bitidx + 1'b1;
                            if (bitidx == LAST_BIT) state <= AFTER_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == CNT_END) begin
                            cnt   <= '0;
                            state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == CNT_END) begin
                            data_out    <= shreg;
                            frame_err   <= ~rxs;
                            overrun_err <= overrun_err | rdy;
                            rdy         <= 1'b1;
                            cnt         <= '0;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven at 64 clk per bit, expected
// outcomes are queued at issue time and checked whenever busy drops.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int BIT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enb = 1'b0;
    logic          rx = 1'b1;
    logic          rdy_clr = 1'b0;
    logic [DB-1:0] data_out;
    logic          rdy, busy, frame_err, parity_err, overrun_err;

    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .rx          (rx),
        .rdy_clr     (rdy_clr),
        .data_out    (data_out),
        .rdy         (rdy),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] d;
        logic          r;
        logic          fe;
        logic          pe;
        logic          ov;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   enb_k = 0;
    logic mon_pb = 1'b0;

    // Reference state of the host-visible outputs
    logic [DB-1:0] m_d = '0;
    logic          m_r = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0;

    initial forever begin
        @(negedge clk);
        enb = (enb_k % 4 == 0);
        enb_k++;
    end

    function automatic exp_t snap();
        exp_t e;
        e.d = m_d; e.r = m_r; e.fe = m_fe; e.pe = m_pe; e.ov = m_ov;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e.d = data_out; e.r = rdy; e.fe = frame_err; e.pe = parity_err; e.ov = overrun_err;
        return e;
    endfunction

    // Monitor: every busy fall is a frame end, false start or reset abort.
    initial forever begin
        @(negedge clk);
        if (mon_pb && !busy) begin
            exp_t got, e;
            got = observed();
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_end got=%h (no entry queued)", got);
            end else begin
                e = q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL frame_end got d=%h r=%b fe=%b pe=%b ov=%b want d=%h r=%b fe=%b pe=%b ov=%b",
                             got.d, got.r, got.fe, got.pe, got.ov, e.d, e.r, e.fe, e.pe, e.ov);
                end
            end
        end
        mon_pb = busy;
    end

    task automatic check_now(input string name);
        exp_t got, e;
        got = observed();
        e = snap();
        total++;
        if (got !== e || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s got d=%h r=%b fe=%b pe=%b ov=%b busy=%b want d=%h r=%b fe=%b pe=%b ov=%b busy=0",
                     name, got.d, got.r, got.fe, got.pe, got.ov, busy, e.d, e.r, e.fe, e.pe, e.ov);
        end
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DB-1:0] d, input logic stop, input logic par);
        m_ov = m_ov | m_r;
        m_d  = d;
        m_fe = ~stop;
`ifdef UART_RX_PARITY_EN
        m_pe = (^d) != par;
`else
        m_pe = 1'b0;
`endif
        m_r  = 1'b1;
        q.push_back(snap());
        // A low stop bit keeps the line low after the sample: one extra false start.
        if (!stop) q.push_back(snap());
        hold_bit(1'b0);
        for (int i = 0; i < DB; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par);
`endif
        hold_bit(stop);
        rx = 1'b1;
    endtask

    task automatic clear();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
        m_r  = 1'b0;
        m_ov = 1'b0;
        check_now("rdy_clr");
    endtask

    task automatic glitch();
        q.push_back(snap());
        rx = 1'b0;
        repeat (12) @(negedge clk);
        idle(2 * BIT);
    endtask

    task automatic reset_mid_frame();
        m_d = '0; m_r = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
        q.push_back(snap());
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check_now("reset_mid_frame");
        @(negedge clk);
        rst = 1'b0;
        idle(2 * BIT);
    endtask

    initial begin
        logic [DB-1:0] rd;
        logic          rs, rp;
        repeat (5) @(negedge clk);
        check_now("reset_values");
        rst = 1'b0;
        idle(20);

        send(8'hA5, 1'b1, 1'b0);
        idle(2 * BIT);
        clear();
        glitch();

        send(8'h3C, 1'b0, 1'b0);
        idle(3 * BIT);
        send(8'h01, 1'b1, 1'b1);
        idle(2 * BIT);
        clear();

        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        idle(2 * BIT);
        clear();

        reset_mid_frame();
        send(8'h5A, 1'b1, 1'b0);
        idle(2 * BIT);
        clear();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        idle(2 * BIT);
        send(8'h07, 1'b1, 1'b1);
        idle(2 * BIT);
        clear();
`endif

        for (int n = 0; n < 10; n++) begin
            rd = DB'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rp = (^rd) ^ 1'($urandom_range(0, 1));
            send(rd, rs, rp);
            idle(rs ? 100 + $urandom_range(0, 60) : 3 * BIT + $urandom_range(0, 60));
            if ($urandom_range(0, 1) == 1) clear();
        end

        idle(4 * BIT);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_entries got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
